// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM
// encoding, default latencies and the counter load helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned LAT_MUL_DEF = 4;
  localparam int unsigned LAT_DIV_DEF = 8;
  localparam int unsigned CNT_W       = 4;

  // Counter preload: the capture edge is the one where the count reaches
  // zero, so load latency-1 to land exactly LAT edges after acceptance.
  function automatic logic [CNT_W-1:0] lat_load(input logic is_div,
                                                input int unsigned lat_mul,
                                                input int unsigned lat_div);
    int unsigned l;
    l = is_div ? lat_div : lat_mul;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the datapath settle.
module muldiv_lat_cnt
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for the combinational mul/div datapath. Holds the
// operands on md_* while the datapath settles, captures {hi,lo}, stalls the
// pipeline via busy, and services MTHI/MTLO, flush and divide-by-zero.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned LAT_MUL = LAT_MUL_DEF,
  parameter int unsigned LAT_DIV = LAT_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_r1,
  input  logic [31:0] md_r2,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [1:0]  md_op_q, md_op_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  muldiv_lat_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (lat_load(op[1], LAT_MUL, LAT_DIV)),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state and datapath control. Flush beats both acceptance and the
  // capture edge; MTHI/MTLO only land while idle.
  always_comb begin
    state_d    = state_q;
    md_op_d    = md_op_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          if (op[1] && (b == '0)) begin
            // Zero divisor: finish immediately, HI/LO untouched.
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            md_op_d  = op;
            md_a_d   = a;
            md_b_d   = b;
            cnt_load = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          lo_d    = md_r1;
          hi_d    = md_r2;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      md_op_q    <= '0;
      md_a_q     <= '0;
      md_b_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_op_q    <= md_op_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign md_op    = md_op_q;
  assign md_a     = md_a_q;
  assign md_b     = md_b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + random bench for muldiv_ctrl with a combinational datapath
// model and a magnitude/sign reference for expected HI/LO.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LM = 4;
  localparam int LD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b, md_r1, md_r2, hi, lo;
  logic        busy, done, div_zero;
  logic [63:0] dp;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.LAT_MUL(LM), .LAT_DIV(LD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_r1(md_r1), .md_r2(md_r2),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Datapath stand-in: {remainder/product_hi, quotient/product_lo}.
  always_comb begin
    dp = '0;
    case (md_op)
      OP_MULT:  dp = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
      OP_MULTU: dp = {32'b0, md_a} * {32'b0, md_b};
      OP_DIV: if (md_b != '0) begin
        if (md_a == 32'h8000_0000 && md_b == 32'hFFFF_FFFF)
          dp = {32'h0, md_a};
        else
          dp = {32'($signed(md_a) % $signed(md_b)), 32'($signed(md_a) / $signed(md_b))};
      end
      default: if (md_b != '0) dp = {md_a % md_b, md_a / md_b};
    endcase
  end
  assign {md_r2, md_r1} = dp;

  // Reference {hi,lo}: unsigned magnitudes, then apply MIPS sign rules.
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my, q, r;
    logic [63:0] p;
    logic        sgn, neg;
    sgn = !o[0];
    mx  = (sgn && x[31]) ? -x : x;
    my  = (sgn && y[31]) ? -y : y;
    neg = sgn && (x[31] ^ y[31]);
    if (!o[1]) begin
      p = {32'b0, mx} * {32'b0, my};
      return neg ? -p : p;
    end
    q = mx / my;
    r = mx % my;
    if (neg) q = -q;
    if (sgn && x[31]) r = -r;
    return {r, q};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for done; returns number of edges taken.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 20 && !done; i++) begin
      step();
      edges = i;
    end
  endtask

  // Issue one op, scramble the request inputs while running, check latency,
  // operand hold, busy, and the final HI/LO.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int          edges, lat;
    logic        held, busy_ok;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    if (o[1] && y == '0) begin
      chkb("dz_done", done, 1'b1);
      chkb("dz_flag", div_zero, 1'b1);
      chkb("dz_busy", busy, 1'b0);
      chk64("dz_hilo", {hi, lo}, {hi0, lo0});
      return;
    end
    lat = o[1] ? LD : LM;
    chkb("accept_busy", busy, 1'b1);
    held = 1'b1; busy_ok = 1'b1; edges = 0;
    for (int i = 1; i <= 20 && !done; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom);
      step();
      edges = i;
      if (md_a !== x || md_b !== y || md_op !== o) held = 1'b0;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk32("latency", edges, lat);
    chkb("md_held", held, 1'b1);
    chkb("busy_run", busy_ok, 1'b1);
    chkb("done_end", done, 1'b1);
    chkb("busy_end", busy, 1'b0);
    chkb("dz_end", div_zero, 1'b0);
    chk64("hilo", {hi, lo}, ref_hilo(o, x, y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    logic seen;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    // Reset values
    #2;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_dz", div_zero, 1'b0);
    chk64("rst_hilo", {hi, lo}, 64'h0);
    chk32("rst_md_a", md_a, 32'h0);
    chk32("rst_md_b", md_b, 32'h0);
    chk32("rst_md_op", {30'b0, md_op}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: signed multiply
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk64("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // 2: MULTU then back-to-back DIV in the done cycle
    step();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk64("t2_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk64("t2_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    step();

    // 3: preload via MTHI/MTLO, then divide by zero
    hi_we = 1'b1; wdata = 32'h11; step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; step();
    lo_we = 1'b0;
    chk64("t3_preload", {hi, lo}, {32'h11, 32'h22});
    run_op(OP_DIVU, 32'd100, 32'd0);
    step();
    chkb("t3_done_clr", done, 1'b0);
    chkb("t3_dz_clr", div_zero, 1'b0);
    chkb("t3_busy", busy, 1'b0);

    // 4: flush mid-run, ignored second start
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; step();
    op = OP_MULT; a = 32'd555; b = 32'd9; step();
    chk32("t4_md_a", md_a, 32'd100);
    chk32("t4_md_op", {30'b0, md_op}, {30'b0, OP_DIVU});
    start = 1'b0; step();
    flush = 1'b1; step();
    flush = 1'b0;
    chkb("t4_busy", busy, 1'b0);
    chkb("t4_done", done, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (done) seen = 1'b1; end
    chkb("t4_no_done", seen, 1'b0);
    chk64("t4_hilo", {hi, lo}, {32'h11, 32'h22});

    // flush with start in idle: request dropped
    op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1; step();
    start = 1'b0; flush = 1'b0;
    chkb("idle_flush_busy", busy, 1'b0);
    step();
    chkb("idle_flush_done", done, 1'b0);

    // flush on the capture edge wins
    start = 1'b1; step();
    start = 1'b0; step(); step(); step();
    flush = 1'b1; step();
    flush = 1'b0;
    chkb("cap_flush_busy", busy, 1'b0);
    chkb("cap_flush_done", done, 1'b0);
    chk64("cap_flush_hilo", {hi, lo}, {32'h11, 32'h22});

    // 5: MTHI ignored while running, honoured when idle
    op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1; step();
    start = 1'b0; hi_we = 1'b1; wdata = 32'hABCD; step();
    hi_we = 1'b0;
    chk32("t5_hi_run", hi, 32'h11);
    wait_done(edges);
    chkb("t5_done", done, 1'b1);
    chk64("t5_hilo", {hi, lo}, {32'h0, 32'd42});
    hi_we = 1'b1; wdata = 32'hABCD; step();
    hi_we = 1'b0;
    chk32("t5_mthi", hi, 32'hABCD);

    // same-cycle start + MTHI: write lands, capture overwrites later
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1; hi_we = 1'b1; wdata = 32'h5555; step();
    start = 1'b0; hi_we = 1'b0;
    chk32("sc_hi", hi, 32'h5555);
    chkb("sc_busy", busy, 1'b1);
    wait_done(edges);
    chk32("sc_lat", edges, LM);
    chk64("sc_hilo", {hi, lo}, {32'h0, 32'd12});
    step();

    // 6: reset mid-multiply
    op = OP_MULT; a = 32'd1234; b = 32'd5678; start = 1'b1; step();
    start = 1'b0; step();
    rst_n = 1'b0; #1;
    chkb("t6_busy", busy, 1'b0);
    chk64("t6_hilo", {hi, lo}, 64'h0);
    chk32("t6_md_a", md_a, 32'h0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (done) seen = 1'b1; end
    chkb("t6_no_done", seen, 1'b0);

    // Random ops, including occasional zero divisors
    for (int k = 0; k < 24; k++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_op(ro, rx, ry);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
